// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the write-back arbiter and its long-result queue:
// default data/address widths, the default queue depth, the write-port source
// selector and a helper for the queue counter width.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

  localparam int WB_DSIZE  = 32;  // register data width
  localparam int WB_ASIZE  = 5;   // register address width
  localparam int WB_QDEPTH = 4;   // long-result queue depth (power of 2, >= 2)

  // Source that owns the register-file write port in the next cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,  // nothing selected: wen drops, address/data hold
    SEL_ALU  = 2'd1,  // single-cycle ALU result
    SEL_POP  = 2'd2,  // queue head (written only when not killed)
    SEL_BYP  = 2'd3   // long result straight through an empty queue
  } wb_sel_e;

  // Pointer/count width: index bits plus one wrap bit
  function automatic int wbq_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_wbq_fifo.sv
// -----------------------------------------------------------------------------
// wbq_fifo
// Circular queue of pending long-op results {waddr, wdata, kill}. Pointers carry
// a wrap bit so full and empty are told apart without a separate counter.
// Entries whose address matches the kill address are marked dead in place; a
// dead head still has to be popped but must not be written.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   i_push, i_push_addr/data   enqueue at tail (ignored when full)
//   i_push_kill                enqueued entry starts already killed
//   i_pop                      drop head (ignored when empty)
//   i_kill_en, i_kill_addr     kill every live entry with this address
//   i_raddr1, i_raddr2         addresses checked against live entries
//   o_full, o_empty, o_count   occupancy (killed entries still count)
//   o_head_addr/data/kill      current head entry
//   o_hit1, o_hit2             a live entry targets raddr1/raddr2 (never r0)
// -----------------------------------------------------------------------------
module wbq_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DSIZE  = WB_DSIZE,
  parameter int ASIZE  = WB_ASIZE,
  parameter int QDEPTH = WB_QDEPTH,
  localparam int PW    = $clog2(QDEPTH),
  localparam int CW    = wbq_cnt_width(QDEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [ASIZE-1:0] i_push_addr,
  input  logic [DSIZE-1:0] i_push_data,
  input  logic             i_push_kill,
  input  logic             i_pop,
  input  logic             i_kill_en,
  input  logic [ASIZE-1:0] i_kill_addr,
  input  logic [ASIZE-1:0] i_raddr1,
  input  logic [ASIZE-1:0] i_raddr2,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [ASIZE-1:0] o_head_addr,
  output logic [DSIZE-1:0] o_head_data,
  output logic             o_head_kill,
  output logic             o_hit1,
  output logic             o_hit2
);

  localparam logic [CW-1:0] PTR_ONE = CW'(1);

  logic [ASIZE-1:0]  r_addr [QDEPTH];
  logic [DSIZE-1:0]  r_data [QDEPTH];
  logic [QDEPTH-1:0] r_kill;
  logic [QDEPTH-1:0] r_valid;
  logic [CW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_rd_ptr;

  logic [PW-1:0]     w_wr_idx;
  logic [PW-1:0]     w_rd_idx;
  logic              w_push;
  logic              w_pop;

  assign w_wr_idx = r_wr_ptr[PW-1:0];
  assign w_rd_idx = r_rd_ptr[PW-1:0];

  // Same index but different wrap bit means the writer has lapped the reader
  assign o_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[CW-1] != r_rd_ptr[CW-1]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_count = r_wr_ptr - r_rd_ptr;

  // Guard the handshake here too so a misbehaving parent cannot corrupt the ring
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_head_addr = r_addr[w_rd_idx];
  assign o_head_data = r_data[w_rd_idx];
  assign o_head_kill = r_kill[w_rd_idx];

  // Read/write pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {CW{1'b0}};
      r_rd_ptr <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Entry storage: push at tail, retire at head, mark address matches killed.
  // Push and pop never hit the same slot: that would need the queue to be
  // both empty (no pop) and full (no push).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kill  <= {QDEPTH{1'b0}};
      r_valid <= {QDEPTH{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        r_addr[i] <= {ASIZE{1'b0}};
        r_data[i] <= {DSIZE{1'b0}};
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (w_push && (w_wr_idx == i[PW-1:0])) begin
          r_valid[i] <= 1'b1;
          r_kill[i]  <= i_push_kill;
          r_addr[i]  <= i_push_addr;
          r_data[i]  <= i_push_data;
        end else if (w_pop && (w_rd_idx == i[PW-1:0])) begin
          r_valid[i] <= 1'b0;
          r_kill[i]  <= 1'b0;
        end else if (i_kill_en && r_valid[i] && (r_addr[i] == i_kill_addr)) begin
          r_kill[i]  <= 1'b1;
        end else begin
          r_kill[i]  <= r_kill[i];
        end
      end
    end
  end

  // Pending-write address match over live (valid, not killed) entries
  always_comb begin
    o_hit1 = 1'b0;
    o_hit2 = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (r_valid[i] && !r_kill[i]) begin
        if ((i_raddr1 != {ASIZE{1'b0}}) && (r_addr[i] == i_raddr1)) begin
          o_hit1 = 1'b1;
        end else begin
          o_hit1 = o_hit1;
        end
        if ((i_raddr2 != {ASIZE{1'b0}}) && (r_addr[i] == i_raddr2)) begin
          o_hit2 = 1'b1;
        end else begin
          o_hit2 = o_hit2;
        end
      end else begin
        o_hit1 = o_hit1;
        o_hit2 = o_hit2;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Write-back arbiter: merges single-cycle ALU results and multi-cycle long-op
// results onto one registered register-file write port. The ALU can never be
// stalled, so it always wins; long results wait in wbq_fifo, or bypass it when
// the queue is empty and the port is free. An ALU write squashes any older
// queued write to the same register (WAW), and decode gets pending-write hits.
// Ports:
//   clk, rst                       clock / asynchronous active-low reset
//   alu_valid/waddr/wdata          ALU result (r0 means no write)
//   lng_valid/waddr/wdata, lng_ready  long-op result handshake
//   raddr1, raddr2 -> pend_hit1/2  pending-write check for decode
//   q_count                        queue occupancy, killed entries included
//   wen, waddr, wdata              registered register-file write port
// -----------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DSIZE  = WB_DSIZE,
  parameter int ASIZE  = WB_ASIZE,
  parameter int QDEPTH = WB_QDEPTH,
  localparam int CW    = wbq_cnt_width(QDEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [ASIZE-1:0] alu_waddr,
  input  logic [DSIZE-1:0] alu_wdata,
  input  logic             lng_valid,
  output logic             lng_ready,
  input  logic [ASIZE-1:0] lng_waddr,
  input  logic [DSIZE-1:0] lng_wdata,
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  output logic             pend_hit1,
  output logic             pend_hit2,
  output logic [CW-1:0]    q_count,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata
);

  logic             r_wen;
  logic [ASIZE-1:0] r_waddr;
  logic [DSIZE-1:0] r_wdata;

  logic             w_alu_wr;
  logic             w_lng_acc;
  logic             w_lng_nz;
  logic             w_lng_kill;
  logic             w_push;
  logic             w_pop;
  wb_sel_e          w_sel;

  logic             w_q_full;
  logic             w_q_empty;
  logic [ASIZE-1:0] w_head_addr;
  logic [DSIZE-1:0] w_head_data;
  logic             w_head_kill;
  logic             w_q_hit1;
  logic             w_q_hit2;

  logic             w_nxt_wen;
  logic [ASIZE-1:0] w_nxt_waddr;
  logic [DSIZE-1:0] w_nxt_wdata;

  // Ready depends only on the full flag, not on a same-cycle pop, so there is
  // no combinational path from the arbitration decision back to the producer.
  assign lng_ready  = !w_q_full;
  assign w_alu_wr   = alu_valid && (alu_waddr != {ASIZE{1'b0}});
  assign w_lng_acc  = lng_valid && lng_ready;
  assign w_lng_nz   = w_lng_acc && (lng_waddr != {ASIZE{1'b0}});
  assign w_lng_kill = w_alu_wr && (lng_waddr == alu_waddr);

  // Source selection for next cycle's write port
  always_comb begin
    w_sel = SEL_NONE;
    if (w_alu_wr) begin
      w_sel = SEL_ALU;
    end else if (!w_q_empty) begin
      w_sel = SEL_POP;
    end else if (w_lng_nz) begin
      w_sel = SEL_BYP;
    end else begin
      w_sel = SEL_NONE;
    end
  end

  assign w_pop  = (w_sel == SEL_POP);
  // Any accepted non-r0 long result that is not bypassing goes to the tail
  assign w_push = w_lng_nz && (w_sel != SEL_BYP);

  wbq_fifo #(
    .DSIZE  (DSIZE),
    .ASIZE  (ASIZE),
    .QDEPTH (QDEPTH)
  ) u_wbq_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (w_push),
    .i_push_addr (lng_waddr),
    .i_push_data (lng_wdata),
    .i_push_kill (w_lng_kill),
    .i_pop       (w_pop),
    .i_kill_en   (w_alu_wr),
    .i_kill_addr (alu_waddr),
    .i_raddr1    (raddr1),
    .i_raddr2    (raddr2),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty),
    .o_count     (q_count),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_kill (w_head_kill),
    .o_hit1      (w_q_hit1),
    .o_hit2      (w_q_hit2)
  );

  // Pending hits: live queue entries plus a live long result accepted right now
  always_comb begin
    pend_hit1 = w_q_hit1;
    pend_hit2 = w_q_hit2;
    if (w_lng_nz && !w_lng_kill) begin
      if ((raddr1 != {ASIZE{1'b0}}) && (lng_waddr == raddr1)) begin
        pend_hit1 = 1'b1;
      end else begin
        pend_hit1 = w_q_hit1;
      end
      if ((raddr2 != {ASIZE{1'b0}}) && (lng_waddr == raddr2)) begin
        pend_hit2 = 1'b1;
      end else begin
        pend_hit2 = w_q_hit2;
      end
    end else begin
      pend_hit1 = w_q_hit1;
      pend_hit2 = w_q_hit2;
    end
  end

  // Next write-port value; address/data hold whenever nothing is written
  always_comb begin
    w_nxt_wen   = 1'b0;
    w_nxt_waddr = r_waddr;
    w_nxt_wdata = r_wdata;
    case (w_sel)
      SEL_ALU: begin
        w_nxt_wen   = 1'b1;
        w_nxt_waddr = alu_waddr;
        w_nxt_wdata = alu_wdata;
      end
      SEL_POP: begin
        // A killed head still costs its pop cycle but is never written
        if (!w_head_kill) begin
          w_nxt_wen   = 1'b1;
          w_nxt_waddr = w_head_addr;
          w_nxt_wdata = w_head_data;
        end else begin
          w_nxt_wen   = 1'b0;
        end
      end
      SEL_BYP: begin
        w_nxt_wen   = 1'b1;
        w_nxt_waddr = lng_waddr;
        w_nxt_wdata = lng_wdata;
      end
      SEL_NONE: begin
        w_nxt_wen   = 1'b0;
      end
      default: begin
        w_nxt_wen   = 1'b0;
      end
    endcase
  end

  // Registered register-file write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen   <= 1'b0;
      r_waddr <= {ASIZE{1'b0}};
      r_wdata <= {DSIZE{1'b0}};
    end else begin
      r_wen   <= w_nxt_wen;
      r_waddr <= w_nxt_waddr;
      r_wdata <= w_nxt_wdata;
    end
  end

  assign wen   = r_wen;
  assign waddr = r_waddr;
  assign wdata = r_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed, table-driven bench for wb_arbiter (DSIZE=32, ASIZE=5, QDEPTH=4).
// Each record gives the inputs for one cycle, the combinational outputs
// expected before the clock edge (lng_ready, q_count, pend_hit*) and the
// registered write port expected after it. A hand-written sequence covers
// asynchronous reset with a partly full queue.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int QD = 4;
  localparam int CW = $clog2(QD) + 1;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          lng_valid;
  logic          lng_ready;
  logic [AW-1:0] lng_waddr;
  logic [DW-1:0] lng_wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic          pend_hit1;
  logic          pend_hit2;
  logic [CW-1:0] q_count;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          lv;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic [AW-1:0] r1;
    logic [AW-1:0] r2;
    logic          e_wen;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_rdy;
    logic [CW-1:0] e_cnt;
    logic          e_h1;
    logic          e_h2;
  } vec_t;

  vec_t vecs[$];

  wb_arbiter #(.DSIZE(DW), .ASIZE(AW), .QDEPTH(QD)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .lng_valid (lng_valid),
    .lng_ready (lng_ready),
    .lng_waddr (lng_waddr),
    .lng_wdata (lng_wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .pend_hit1 (pend_hit1),
    .pend_hit2 (pend_hit2),
    .q_count   (q_count),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int av, input int aa, input int ad,
                              input int lv, input int la, input int ld,
                              input int r1, input int r2,
                              input int ew, input int ea, input int ed,
                              input int er, input int ec, input int h1, input int h2);
    vec_t v;
    v.av = av[0];      v.aa = aa[AW-1:0]; v.ad = ad[DW-1:0];
    v.lv = lv[0];      v.la = la[AW-1:0]; v.ld = ld[DW-1:0];
    v.r1 = r1[AW-1:0]; v.r2 = r2[AW-1:0];
    v.e_wen = ew[0];   v.e_waddr = ea[AW-1:0]; v.e_wdata = ed[DW-1:0];
    v.e_rdy = er[0];   v.e_cnt = ec[CW-1:0];
    v.e_h1 = h1[0];    v.e_h2 = h2[0];
    return v;
  endfunction

  task automatic drive_idle();
    alu_valid = 1'b0; alu_waddr = 5'd0; alu_wdata = 32'd0;
    lng_valid = 1'b0; lng_waddr = 5'd0; lng_wdata = 32'd0;
    raddr1 = 5'd0; raddr2 = 5'd0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;

    //        av aa  ad       lv la ld       r1 r2  ew ea ed       rdy cnt h1 h2
    // ALU only, r0 suppression, bypass, dropped r0 long result
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0,  0, 0, 0,       1, 0, 0, 0));
    vecs.push_back(mk(1, 3, 'h1234,   0, 0, 0,       0, 0,  1, 3, 'h1234,  1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 'h5555,   0, 0, 0,       0, 0,  0, 3, 'h1234,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,        1, 5, 'h00AA,  5, 0,  1, 5, 'h00AA,  1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0,  0, 5, 'h00AA,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,        1, 0, 'h77,    0, 0,  0, 5, 'h00AA,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0,  0, 5, 'h00AA,  1, 0, 0, 0));
    // Contention: ALU for 6 cycles, long r1..r5 offered, queue fills at 4
    vecs.push_back(mk(1, 10, 'hA0,    1, 1, 'h101,   0, 0,  1, 10, 'hA0,   1, 0, 0, 0));
    vecs.push_back(mk(1, 11, 'hA1,    1, 2, 'h102,   0, 0,  1, 11, 'hA1,   1, 1, 0, 0));
    vecs.push_back(mk(1, 12, 'hA2,    1, 3, 'h103,   0, 0,  1, 12, 'hA2,   1, 2, 0, 0));
    vecs.push_back(mk(1, 13, 'hA3,    1, 4, 'h104,   0, 0,  1, 13, 'hA3,   1, 3, 0, 0));
    vecs.push_back(mk(1, 14, 'hA4,    1, 5, 'h105,   2, 4,  1, 14, 'hA4,   0, 4, 1, 1));
    vecs.push_back(mk(1, 15, 'hA5,    1, 5, 'h105,   0, 0,  1, 15, 'hA5,   0, 4, 0, 0));
    // ALU stops: drain in order; full blocks r5 during the first pop
    vecs.push_back(mk(0, 0, 0,        1, 5, 'h105,   0, 0,  1, 1, 'h101,   0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0,        1, 5, 'h105,   5, 0,  1, 2, 'h102,   1, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0,  1, 3, 'h103,   1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0,  1, 4, 'h104,   1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0,  1, 5, 'h105,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0,  0, 5, 'h105,   1, 0, 0, 0));
    // Squash: queued r7 killed by ALU r7, then its pop writes nothing
    vecs.push_back(mk(1, 8, 'h3333,   1, 7, 'h1111,  0, 0,  1, 8, 'h3333,  1, 0, 0, 0));
    vecs.push_back(mk(1, 7, 'h2222,   0, 0, 0,       7, 0,  1, 7, 'h2222,  1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       7, 0,  0, 7, 'h2222,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0,  0, 7, 'h2222,  1, 0, 0, 0));
    // Same-cycle kill: long r6 accepted with ALU r6 is enqueued dead
    vecs.push_back(mk(1, 6, 'h600,    1, 6, 'h666,   0, 0,  1, 6, 'h600,   1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       6, 0,  0, 6, 'h600,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       0, 0,  0, 6, 'h600,   1, 0, 0, 0));
    // Pending hits: queue r2 then r9; raddr 0 never hits
    vecs.push_back(mk(1, 1, 'h1,      1, 2, 'h202,   0, 0,  1, 1, 'h1,     1, 0, 0, 0));
    vecs.push_back(mk(1, 3, 'h3,      1, 9, 'h909,   2, 9,  1, 3, 'h3,     1, 1, 1, 1));
    vecs.push_back(mk(1, 4, 'h4,      0, 0, 0,       2, 9,  1, 4, 'h4,     1, 2, 1, 1));
    vecs.push_back(mk(1, 5, 'h5,      0, 0, 0,       0, 0,  1, 5, 'h5,     1, 2, 0, 0));
    vecs.push_back(mk(1, 17, 'hB,     1, 12, 'hC0C,  0, 0,  1, 17, 'hB,    1, 2, 0, 0));

    // Reset state while held
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wen", {31'd0, wen}, 32'd0);
    chk("reset_count", {{(32-CW){1'b0}}, q_count}, 32'd0);
    chk("reset_ready", {31'd0, lng_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      alu_valid = vecs[i].av; alu_waddr = vecs[i].aa; alu_wdata = vecs[i].ad;
      lng_valid = vecs[i].lv; lng_waddr = vecs[i].la; lng_wdata = vecs[i].ld;
      raddr1 = vecs[i].r1; raddr2 = vecs[i].r2;
      #2;
      chk($sformatf("v%0d_ready", i), {31'd0, lng_ready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_count", i), {{(32-CW){1'b0}}, q_count}, {{(32-CW){1'b0}}, vecs[i].e_cnt});
      chk($sformatf("v%0d_hit1", i), {31'd0, pend_hit1}, {31'd0, vecs[i].e_h1});
      chk($sformatf("v%0d_hit2", i), {31'd0, pend_hit2}, {31'd0, vecs[i].e_h2});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wen", i), {31'd0, wen}, {31'd0, vecs[i].e_wen});
      chk($sformatf("v%0d_waddr", i), {27'd0, waddr}, {27'd0, vecs[i].e_waddr});
      chk($sformatf("v%0d_wdata", i), wdata, vecs[i].e_wdata);
    end

    // Async reset mid-cycle with three queued results
    drive_idle();
    #2;
    chk("pre_rst_count", {{(32-CW){1'b0}}, q_count}, 32'd3);
    rst = 1'b0;
    #1;
    chk("async_rst_wen", {31'd0, wen}, 32'd0);
    chk("async_rst_waddr", {27'd0, waddr}, 32'd0);
    chk("async_rst_wdata", wdata, 32'd0);
    chk("async_rst_count", {{(32-CW){1'b0}}, q_count}, 32'd0);
    chk("async_rst_ready", {31'd0, lng_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_wen", k), {31'd0, wen}, 32'd0);
      chk($sformatf("post_rst%0d_count", k), {{(32-CW){1'b0}}, q_count}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
